// File: rtl/dma_engine_if.sv
// Femto peripheral bus bundle between the DMA initiator (master) and a responder (slave).
// Responder answers with m_fault in the m_req cycle, or m_resp (with m_rdata) one or more cycles later.
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_WIDTH
`define BUS_ACC_WIDTH 2
`endif
`ifndef BUS_ACC_4B
`define BUS_ACC_4B 2'd2
`endif

interface dma_engine_if;
    logic [`BUS_WIDTH-1:0]     m_addr;
    logic                      m_w_rb;
    logic [`BUS_ACC_WIDTH-1:0] m_acc;
    logic [`BUS_WIDTH-1:0]     m_wdata;
    logic                      m_req;
    logic [`BUS_WIDTH-1:0]     m_rdata;
    logic                      m_resp;
    logic                      m_fault;

    modport master (
        output m_addr, m_w_rb, m_acc, m_wdata, m_req,
        input  m_rdata, m_resp, m_fault
    );

    modport slave (
        input  m_addr, m_w_rb, m_acc, m_wdata, m_req,
        output m_rdata, m_resp, m_fault
    );
endinterface

// File: rtl/dma_engine.sv
// Word-copy DMA engine: reads len 4-byte words from src, writes them to dst, one bus transaction at a time.
// Latency: 4 cycles per word with single-cycle responder replies; done pulses the cycle after the last write response.
// Backpressure: waits indefinitely for m_resp; m_fault aborts. Optional DMA_FILL_EN adds a write-only fill mode.
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_WIDTH
`define BUS_ACC_WIDTH 2
`endif
`ifndef BUS_ACC_4B
`define BUS_ACC_4B 2'd2
`endif

module dma_engine #(
    parameter int LEN_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [`BUS_WIDTH-1:0] src,
    input  logic [`BUS_WIDTH-1:0] dst,
    input  logic [LEN_WIDTH-1:0]  len,
`ifdef DMA_FILL_EN
    input  logic                  fill,
    input  logic [`BUS_WIDTH-1:0] fill_data,
`endif
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    dma_engine_if.master          bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        WR_WAIT = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [`BUS_WIDTH-1:0]   src_q, src_d;
    logic [`BUS_WIDTH-1:0]   dst_q, dst_d;
    logic [LEN_WIDTH-1:0]    cnt_q, cnt_d;
    logic [`BUS_WIDTH-1:0]   buf_q, buf_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic                    fill_q, fill_d;
    logic                    start_fill;
    logic [`BUS_WIDTH-1:0]   start_fill_data;

`ifdef DMA_FILL_EN
    assign start_fill      = fill;
    assign start_fill_data = fill_data;
`else
    assign start_fill      = 1'b0;
    assign start_fill_data = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            buf_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            fill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            done_q  <= done_d;
            err_q   <= err_d;
            fill_q  <= fill_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        dst_d       = dst_q;
        cnt_d       = cnt_q;
        buf_d       = buf_q;
        done_d      = 1'b0;
        err_d       = err_q;
        fill_d      = fill_q;
        bus.m_req   = 1'b0;
        bus.m_addr  = '0;
        bus.m_w_rb  = 1'b0;
        bus.m_acc   = '0;
        bus.m_wdata = '0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    err_d = 1'b0;
                    if (len == '0) begin
                        done_d = 1'b0 | 1'b1;
                    end else begin
                        src_d  = src;
                        dst_d  = dst;
                        cnt_d  = len;
                        fill_d = start_fill;
                        // Fill mode preloads the write buffer and never reads.
                        if (start_fill) begin
                            buf_d   = start_fill_data;
                            state_d = WR_REQ;
                        end else begin
                            state_d = RD_REQ;
                        end
                    end
                end
            end
            RD_REQ: begin
                bus.m_req  = 1'b1;
                bus.m_addr = src_q;
                bus.m_acc  = `BUS_ACC_4B;
                if (bus.m_fault) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (bus.m_resp) begin
                    buf_d   = bus.m_rdata;
                    state_d = WR_REQ;
                end
            end
            WR_REQ: begin
                bus.m_req   = 1'b1;
                bus.m_addr  = dst_q;
                bus.m_w_rb  = 1'b1;
                bus.m_acc   = `BUS_ACC_4B;
                bus.m_wdata = buf_q;
                if (bus.m_fault) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    state_d = WR_WAIT;
                end
            end
            WR_WAIT: begin
                if (bus.m_resp) begin
                    src_d = src_q + `BUS_WIDTH'(4);
                    dst_d = dst_q + `BUS_WIDTH'(4);
                    cnt_d = cnt_q - LEN_WIDTH'(1);
                    if (cnt_q == LEN_WIDTH'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else if (fill_q) begin
                        state_d = WR_REQ;
                    end else begin
                        state_d = RD_REQ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_dma_engine.sv
// Directed bench for dma_engine: a bus responder pops expected transactions from a scoreboard queue.
module tb_dma_engine;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [31:0] src = '0;
    logic [31:0] dst = '0;
    logic [15:0] len = '0;
`ifdef DMA_FILL_EN
    logic        fill = 1'b0;
    logic [31:0] fill_data = '0;
`endif
    logic        busy, done, err;

    dma_engine_if bus ();

    dma_engine #(.LEN_WIDTH(16)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .src       (src),
        .dst       (dst),
        .len       (len),
`ifdef DMA_FILL_EN
        .fill      (fill),
        .fill_data (fill_data),
`endif
        .busy      (busy),
        .done      (done),
        .err       (err),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        w;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    txn_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    bit          resp_on = 0;
    int          rd_delay = 1;
    bit          fault_en = 0;
    logic [31:0] fault_addr = '0;
    int          pend = 0;
    logic [31:0] pend_data = '0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return a ^ 32'hC3A5_0F00;
    endfunction

    task automatic push_copy(input logic [31:0] s, input logic [31:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({1'b0, s + 32'(4 * i), 32'h0});
            exp_q.push_back({1'b1, d + 32'(4 * i), mem_val(s + 32'(4 * i))});
        end
    endtask

    // Called #1 after an edge: start is sampled at the next edge (cycle 0), returns in cycle 1.
    task automatic do_start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
        start = 1'b1; src = s; dst = d; len = l;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int extra_at, output int cyc);
        cyc = 1;
        while (done !== 1'b1 && cyc < 500) begin
            if (cyc == extra_at) begin
                start = 1'b1; src = 32'h900; dst = 32'hA00; len = 16'd7;
            end
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
        end
    endtask

    // Responder: replies after pend cycles, injects faults on a chosen write address.
    initial begin
        txn_t e;
        bus.m_resp = 1'b0; bus.m_fault = 1'b0; bus.m_rdata = '0;
        wait (resp_on);
        forever begin
            @(posedge clk); #1;
            bus.m_resp = 1'b0; bus.m_fault = 1'b0; bus.m_rdata = '0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    bus.m_resp = 1'b1;
                    bus.m_rdata = pend_data;
                end
            end
            if (bus.m_req === 1'b1) begin
                check("acc", bus.m_acc, 2'd2);
                check("unexpected_req", (exp_q.size() > 0), 1'b1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("w_rb", bus.m_w_rb, e.w);
                    check("addr", bus.m_addr, e.addr);
                    if (e.w) check("wdata", bus.m_wdata, e.data);
                end
                if (fault_en && bus.m_w_rb && bus.m_addr == fault_addr) begin
                    bus.m_fault = 1'b1;
                end else begin
                    pend = bus.m_w_rb ? 1 : rd_delay;
                    pend_data = mem_val(bus.m_addr);
                end
            end else begin
                check("idle_bus", {bus.m_addr, bus.m_w_rb, bus.m_acc, bus.m_wdata}, 67'd0);
            end
        end
    end

    initial begin
        int cyc;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_req", bus.m_req, 1'b0);
        check("rst_bus", {bus.m_addr, bus.m_w_rb, bus.m_acc, bus.m_wdata}, 67'd0);
        rstn = 1'b1;
        resp_on = 1;
        @(posedge clk); #1;

        // Basic copy of three words.
        push_copy(32'h100, 32'h200, 3);
        do_start(32'h100, 32'h200, 16'd3);
        check("copy_busy1", busy, 1'b1);
        wait_done(0, cyc);
        check("copy_done_cyc", cyc, 13);
        check("copy_busy_at_done", busy, 1'b0);
        check("copy_err", err, 1'b0);
        @(posedge clk); #1;
        check("copy_done_pulse", done, 1'b0);
        check("copy_sb_empty", exp_q.size(), 0);

        // Fault on the second write aborts before touching 0x208.
        fault_en = 1; fault_addr = 32'h204;
        push_copy(32'h100, 32'h200, 2);
        do_start(32'h100, 32'h200, 16'd3);
        wait_done(0, cyc);
        check("fault_done_cyc", cyc, 8);
        check("fault_err", err, 1'b1);
        fault_en = 0;
        repeat (4) @(posedge clk);
        #1;
        check("fault_err_sticky", err, 1'b1);
        check("fault_sb_empty", exp_q.size(), 0);

        // Zero-length start: immediate done, clears err, no traffic.
        do_start(32'h100, 32'h200, 16'd0);
        wait_done(0, cyc);
        check("len0_done_cyc", cyc, 1);
        check("len0_err_clr", err, 1'b0);
        check("len0_busy", busy, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("len0_sb_empty", exp_q.size(), 0);

        // Slow reads plus an ignored start while busy.
        rd_delay = 6;
        push_copy(32'h300, 32'h400, 2);
        do_start(32'h300, 32'h400, 16'd2);
        wait_done(5, cyc);
        check("stall_done_cyc", cyc, 19);
        rd_delay = 1;
        repeat (3) @(posedge clk);
        #1;
        check("stall_busy_after", busy, 1'b0);
        check("stall_sb_empty", exp_q.size(), 0);

        // Address wrap at the top of the address space.
        push_copy(32'hFFFF_FFFC, 32'h800, 2);
        do_start(32'hFFFF_FFFC, 32'h800, 16'd2);
        wait_done(0, cyc);
        check("wrap_done_cyc", cyc, 9);
        @(posedge clk); #1;
        check("wrap_sb_empty", exp_q.size(), 0);

`ifdef DMA_FILL_EN
        // Fill mode writes only.
        exp_q.push_back({1'b1, 32'h40, 32'hDEAD_BEEF});
        exp_q.push_back({1'b1, 32'h44, 32'hDEAD_BEEF});
        fill = 1'b1; fill_data = 32'hDEAD_BEEF;
        do_start(32'h1000, 32'h40, 16'd2);
        fill = 1'b0;
        wait_done(0, cyc);
        check("fill_done_cyc", cyc, 5);
        @(posedge clk); #1;
        check("fill_sb_empty", exp_q.size(), 0);
`endif

        // Reset during RD_WAIT; the late read response must not trigger a write.
        rd_delay = 4;
        exp_q.push_back({1'b0, 32'h500, 32'h0});
        do_start(32'h500, 32'h600, 16'd2);
        @(posedge clk); #1;
        check("mid_busy", busy, 1'b1);
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_err", err, 1'b0);
        check("mid_rst_req", bus.m_req, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        check("mid_busy_after", busy, 1'b0);
        check("mid_done_after", done, 1'b0);
        check("mid_sb_empty", exp_q.size(), 0);
        rd_delay = 1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
